imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer-side companion to the 1024-word instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into the instruction memory's write port at consecutive word addresses starting at 0.
- Holds the CPU in stall until the requested program image has been fully written.

Parameters:
- ADDR_W, 10, word-address bits of the instruction memory; depth = 2^ADDR_W words.
- CNT_W, ADDR_W+1, width of the word counter; must be able to hold the full depth.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  one-cycle pulse; begins a load of word_count words.
- word_count  input  CNT_W  number of words to load; sampled only on an accepted start.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write enable.
- mem_addr  output  32  byte address. Bits [1:0] = 0 and bits above ADDR_W+1 = 0; memory indexes with mem_addr[ADDR_W+1:2].
- mem_wdata  output  32  assembled word.
- busy  output  1  load in progress.
- done  output  1  last load completed; held until the next accepted start.
- cpu_hold  output  1  CPU must stall / keep the PC at 0 while high.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state = IDLE.
  - in_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, busy = 0, done = 0, cpu_hold = 1.
  - Byte and word counters cleared.
  - Reset mid-load aborts immediately. Partially written memory is left as is. No further writes occur.
- States are IDLE, RECV, WRITE, DONE.
- IDLE / DONE:
  - in_ready = 0.
  - start = 1 latches the target count as min(word_count, 2^ADDR_W), clears byte_idx and word_idx, and sets busy = 1, done = 0, cpu_hold = 1.
  - Next state is RECV, or DONE if the target is 0.
  - For a target of 0: DONE is entered the cycle after start, with done = 1 and cpu_hold = 0, and no writes occur.
- RECV:
  - in_ready = 1 combinationally.
  - A byte is accepted when in_valid & in_ready at a clock edge.
  - Byte k (k = 0..3) goes to word bits [8k+7:8k], so the first byte is the LSB.
  - byte_idx increments on each accept and wraps 3 -> 0.
  - Acceptance of the 4th byte moves to WRITE.
  - in_valid low causes no state change, with no timeout.
- WRITE (exactly one cycle):
  - mem_we = 1, mem_wdata = assembled word, mem_addr = word_idx << 2.
  - in_ready = 0; any byte offered is not accepted.
  - word_idx increments.
  - If the new word_idx equals the target, next state is DONE (busy = 0, done = 1, cpu_hold = 0). Otherwise next state is RECV.
- Throughput: 5 cycles per word maximum (4 accepts + 1 write).
- start asserted while busy is ignored.
- start in DONE restarts the load, with cpu_hold raised again in the same edge.
- mem_we is never high outside WRITE.
- mem_addr and mem_wdata hold their last values outside WRITE.
- The memory write port is synchronous. A write is visible to a combinational read one cycle after the WRITE edge.
- Maximum target 1024: last write at mem_addr 0x00000FFC, and word_idx must not wrap before the DONE compare.

Test Plan:
- Reset, then idle 5 cycles -> cpu_hold = 1, busy = 0, done = 0, mem_we never asserted.
- start with word_count = 2; stream 78 56 34 12 EF BE AD DE with in_valid held high. Required:
  - mem_we at addr 0x0 with data 0x12345678.
  - mem_we at addr 0x4 with data 0xDEADBEEF.
  - done = 1 and cpu_hold = 0 on the cycle after the second write.
  - 10 cycles total from the first accept.
- Same load with in_valid toggling 1-0-1-0 -> identical writes. Bytes are accepted only on in_valid & in_ready. No byte is accepted during WRITE.
- start with word_count = 0 -> done = 1 the next cycle, no mem_we. With word_count = 2000 -> clamped to 1024 words, last write at 0x00000FFC, then done.
- Pulse start again mid-load, after 3 words -> ignored; the load still completes at the original count.
- rst_n low after 2 bytes of word 1 -> next cycle: state IDLE, busy = 0, cpu_hold = 1, no write. A fresh start then writes word 0 at addr 0x0.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: packs little-endian bytes into
// 32-bit words, writes them at consecutive word addresses and stalls the CPU until done.
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] word_count,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             cpu_hold
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** ADDR_W);

    state_t           state, state_nx;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] word_idx;
    logic [CNT_W-1:0] word_nx;
    logic [CNT_W-1:0] clamped;
    logic [1:0]       byte_idx;
    logic [23:0]      wbuf;
    wr_t              wr_q;
    logic             start_ok;
    logic             accept;

    assign start_ok = start && (state == IDLE || state == DONE);
    assign accept   = (state == RECV) && in_valid;
    assign clamped  = (word_count > DEPTH) ? DEPTH : word_count;
    // word_idx is one bit wider than the address so a full-depth load reaches the compare
    assign word_nx  = word_idx + CNT_W'(1);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = (clamped == '0) ? DONE : RECV;
            RECV:       if (in_valid && byte_idx == 2'd3) state_nx = WRITE;
            WRITE:      state_nx = (word_nx == target) ? DONE : RECV;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            target   <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            wbuf     <= '0;
            wr_q     <= '0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                target   <= clamped;
                word_idx <= '0;
                byte_idx <= '0;
            end
            if (accept) begin
                byte_idx <= byte_idx + 2'd1;
                // the 4th byte completes the word; latch it with its address for the WRITE cycle
                if (byte_idx == 2'd3) begin
                    wr_q.data <= {in_data, wbuf};
                    wr_q.addr <= {{(30-ADDR_W){1'b0}}, word_idx[ADDR_W-1:0], 2'b00};
                end else begin
                    wbuf[{byte_idx, 3'b000} +: 8] <= in_data;
                end
            end
            if (state == WRITE) word_idx <= word_nx;
        end
    end

    assign in_ready  = (state == RECV);
    assign mem_we    = (state == WRITE);
    assign mem_addr  = wr_q.addr;
    assign mem_wdata = wr_q.data;
    assign busy      = (state == RECV) || (state == WRITE);
    assign done      = (state == DONE);
    assign cpu_hold  = (state != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of loads plus random loads, checked
// against a byte-queue model of the expected memory writes.
module tb_imem_loader;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 11;
    localparam int DEPTH  = 1024;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] word_count = '0;
    logic [7:0]       in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready, mem_we, busy, done, cpu_hold;
    logic [31:0]      mem_addr, mem_wdata;

    imem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          wc;
        int          vmode;     // 0 valid held, 1 toggling, 2 random
        bit          fixed;     // use 78 56 34 12 EF BE AD DE pattern
        int          mid;       // nonzero: pulse start with this count after 3 writes
        int          exp_n;
        logic [31:0] exp_last;
        int          exp_cyc;   // nonzero: cycles from first accept to done
    } vec_t;

    wr_t        wq[$];
    logic [7:0] bq[$];
    logic [7:0] fixb[8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    int         vecs = 0;
    int         miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // write monitor: the memory sees a write for every cycle mem_we is high
    always @(negedge clk) begin
        if (mem_we) begin
            wq.push_back('{mem_addr, mem_wdata});
            chk("ready_during_write", {31'b0, in_ready}, 32'd0);
        end
    end

    task automatic run_load(input int wc, input int vmode, input bit fixed, input int mid,
                            output int cyc, output int first);
        int nw, nb, bi, budget;
        bit pulsed;
        nw = (wc > DEPTH) ? DEPTH : wc;
        nb = nw * 4;
        bq.delete();
        for (int i = 0; i < nb; i++) bq.push_back(fixed ? fixb[i % 8] : 8'($urandom));
        wq.delete();
        start = 1'b1;
        word_count = CNT_W'(wc);
        tick();
        start = 1'b0;
        if (nw > 0) begin
            chk("hold_after_start", {31'b0, cpu_hold}, 32'd1);
            chk("busy_after_start", {31'b0, busy}, 32'd1);
        end
        bi = 0; cyc = 0; first = -1; pulsed = 0;
        budget = nb * 20 + 50;
        while (!done && cyc < budget) begin
            case (vmode)
                0:       in_valid = (bi < nb);
                1:       in_valid = (cyc % 2 == 0) && (bi < nb);
                default: in_valid = ($urandom_range(0, 2) != 0) && (bi < nb);
            endcase
            in_data = (bi < nb) ? bq[bi] : 8'($urandom);
            if (mid != 0 && !pulsed && wq.size() >= 3) begin
                start = 1'b1;
                word_count = CNT_W'(mid);
                pulsed = 1;
            end
            if (in_valid && in_ready) begin
                if (first < 0) first = cyc;
                bi++;
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        if (!done) chk("load_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_load(input int wc);
        int nw;
        logic [31:0] w;
        nw = (wc > DEPTH) ? DEPTH : wc;
        chk("done_at_end", {31'b0, done}, 32'd1);
        chk("hold_at_end", {31'b0, cpu_hold}, 32'd0);
        chk("busy_at_end", {31'b0, busy}, 32'd0);
        chk("write_count", wq.size(), nw);
        for (int i = 0; i < nw && i < wq.size(); i++) begin
            w = 32'(bq[4*i]) | (32'(bq[4*i+1]) << 8) | (32'(bq[4*i+2]) << 16) | (32'(bq[4*i+3]) << 24);
            chk("write_addr", wq[i].addr, 32'(i * 4));
            chk("write_data", wq[i].data, w);
        end
    endtask

    vec_t tbl[7];

    initial begin
        int cyc, first, bi, wc;
        tbl[0] = '{2,    0, 1, 0, 2,    32'h4,   10};
        tbl[1] = '{2,    1, 1, 0, 2,    32'h4,   0};
        tbl[2] = '{0,    0, 0, 0, 0,    32'h0,   0};
        tbl[3] = '{2000, 0, 0, 0, 1024, 32'hFFC, 0};
        tbl[4] = '{5,    0, 0, 2, 5,    32'h10,  0};
        tbl[5] = '{1024, 1, 0, 0, 1024, 32'hFFC, 0};
        tbl[6] = '{1,    2, 0, 0, 1,    32'h0,   0};

        // reset then idle
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_hold", {31'b0, cpu_hold}, 32'd1);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_done", {31'b0, done}, 32'd0);
        chk("idle_ready", {31'b0, in_ready}, 32'd0);
        chk("idle_addr", mem_addr, 32'd0);
        chk("idle_wdata", mem_wdata, 32'd0);
        chk("idle_no_writes", wq.size(), 32'd0);

        foreach (tbl[t]) begin
            run_load(tbl[t].wc, tbl[t].vmode, tbl[t].fixed, tbl[t].mid, cyc, first);
            check_load(tbl[t].wc);
            if (tbl[t].exp_n > 0 && wq.size() > 0) chk("last_addr", wq[wq.size()-1].addr, tbl[t].exp_last);
            if (tbl[t].exp_n == 0) chk("zero_count_latency", cyc, 32'd0);
            if (tbl[t].exp_cyc != 0) chk("cycles_first_to_done", cyc - first, tbl[t].exp_cyc);
            if (tbl[t].fixed && wq.size() >= 2) begin
                chk("fixed_word0", wq[0].data, 32'h12345678);
                chk("fixed_word1", wq[1].data, 32'hDEADBEEF);
            end
        end

        for (int r = 0; r < 8; r++) begin
            wc = $urandom_range(0, 24);
            run_load(wc, 2, 0, 0, cyc, first);
            check_load(wc);
        end

        // reset during the second word: abort without further writes
        wq.delete();
        start = 1'b1;
        word_count = CNT_W'(2);
        tick();
        start = 1'b0;
        bi = 0;
        for (int c = 0; c < 30 && bi < 6; c++) begin
            in_valid = 1'b1;
            in_data = fixb[bi];
            if (in_ready) bi++;
            tick();
        end
        chk("pre_reset_writes", wq.size(), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hold", {31'b0, cpu_hold}, 32'd1);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        repeat (8) tick();
        in_valid = 1'b0;
        chk("no_write_after_reset", wq.size(), 32'd1);
        run_load(1, 0, 1, 0, cyc, first);
        check_load(1);
        if (wq.size() > 0) chk("fresh_word0", wq[0].data, 32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
